// File: rtl/octal_seq_pkg.sv
// Shared types and helpers for the chunked octal subtraction sequencer.
// Holds chunk/digit widths, the sequencer state enum and the chunk borrow rule.
package octal_seq_pkg;

    localparam int CHUNK_W = 6;
    localparam int DIGIT_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        NEG  = 2'd2,
        DONE = 2'd3
    } seq_state_e;

    // Borrow out of one 2-digit chunk: a < b + cin, evaluated one bit wider
    function automatic logic chunk_borrow(
        input logic [CHUNK_W-1:0] a,
        input logic [CHUNK_W-1:0] b,
        input logic               cin
    );
        return {1'b0, a} < ({1'b0, b} + {{CHUNK_W{1'b0}}, cin});
    endfunction

endpackage

// File: rtl/octal_sub.sv
// Two-digit (6-bit) octal subtract datapath with borrow in/out.
// Ports: a_i, b_i (6b operands), cin_i (borrow in), d_o (difference), bout_o (borrow out).
module octal_sub
    import octal_seq_pkg::*;
(
    input  logic [CHUNK_W-1:0] a_i,
    input  logic [CHUNK_W-1:0] b_i,
    input  logic               cin_i,
    output logic [CHUNK_W-1:0] d_o,
    output logic               bout_o
);

    // Binary mod-64 subtraction is exactly 2-digit octal subtraction
    assign d_o    = a_i - b_i - {{(CHUNK_W-1){1'b0}}, cin_i};
    assign bout_o = chunk_borrow(a_i, b_i, cin_i);

endmodule

// File: rtl/octal_sub_seq.sv
// Multi-digit octal subtractor: one shared 6-bit octal_sub, one chunk per cycle,
// LS chunk first. Ports: clk, rst (async high), in_valid/in_ready + a/b operands,
// out_valid/out_ready + d/borrow_out result. Macro OCTAL_SEQ_NEG_EN adds a NEG
// pass that turns a negative result into its magnitude (borrow_out is the sign).
module octal_sub_seq
    import octal_seq_pkg::*;
#(
    parameter int DIGITS = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DIGIT_W*DIGITS-1:0] a,
    input  logic [DIGIT_W*DIGITS-1:0] b,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DIGIT_W*DIGITS-1:0] d,
    output logic                      borrow_out
);

    localparam int W      = DIGIT_W * DIGITS;
    localparam int CHUNKS = DIGITS / 2;
    localparam int IDX_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(CHUNKS - 1);

    seq_state_e         state_q;
    logic [W-1:0]       a_q;
    logic [W-1:0]       b_q;
    logic [W-1:0]       d_q;
    logic [IDX_W-1:0]   idx_q;
    logic               borrow_q;
    logic               borrow_out_q;
    logic               in_ready_q;
    logic               out_valid_q;

    logic [CHUNK_W-1:0] sub_a_d;
    logic [CHUNK_W-1:0] sub_b_d;
    logic [CHUNK_W-1:0] sub_d;
    logic               sub_bout;

    // Operand select for the shared datapath; NEG computes 0 - d chunkwise
    always_comb begin
        sub_a_d = a_q[idx_q*CHUNK_W +: CHUNK_W];
        sub_b_d = b_q[idx_q*CHUNK_W +: CHUNK_W];
`ifdef OCTAL_SEQ_NEG_EN
        if (state_q == NEG) begin
            sub_a_d = '0;
            sub_b_d = d_q[idx_q*CHUNK_W +: CHUNK_W];
        end
`endif
    end

    octal_sub u_sub (
        .a_i    (sub_a_d),
        .b_i    (sub_b_d),
        .cin_i  (borrow_q),
        .d_o    (sub_d),
        .bout_o (sub_bout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            d_q          <= '0;
            idx_q        <= '0;
            borrow_q     <= 1'b0;
            borrow_out_q <= 1'b0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q        <= a;
                        b_q        <= b;
                        idx_q      <= '0;
                        borrow_q   <= 1'b0;
                        in_ready_q <= 1'b0;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    d_q[idx_q*CHUNK_W +: CHUNK_W] <= sub_d;
                    borrow_q <= sub_bout;
                    idx_q    <= idx_q + 1'b1;
                    if (idx_q == LAST) begin
                        idx_q        <= '0;
                        borrow_out_q <= sub_bout;
`ifdef OCTAL_SEQ_NEG_EN
                        if (sub_bout) begin
                            borrow_q <= 1'b0;
                            state_q  <= NEG;
                        end else begin
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end
`else
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
`endif
                    end
                end
`ifdef OCTAL_SEQ_NEG_EN
                NEG: begin
                    d_q[idx_q*CHUNK_W +: CHUNK_W] <= sub_d;
                    borrow_q <= sub_bout;
                    idx_q    <= idx_q + 1'b1;
                    if (idx_q == LAST) begin
                        idx_q       <= '0;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
`endif
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign d          = d_q;
    assign borrow_out = borrow_out_q;

endmodule
